// File: rtl/ds_scan_latch_if.sv
// rtl/ds_scan_latch_if.sv - result/display bus between counter chain, scan latch and display driver
interface ds_scan_latch_if;
  logic       EOC;
  logic       DU;
  logic       HALF;
  logic [3:0] D3;
  logic [3:0] D2;
  logic [3:0] D1;
  logic       POL;
  logic       OVR;
  logic [3:0] Q;
  logic [3:0] DS;
  logic       OR_N;
  logic       DSYNC;

  modport master (
    output EOC, DU, HALF, D3, D2, D1, POL, OVR,
    input  Q, DS, OR_N, DSYNC
  );

  modport slave (
    input  EOC, DU, HALF, D3, D2, D1, POL, OVR,
    output Q, DS, OR_N, DSYNC
  );
endinterface

// File: rtl/ds_scan_latch.sv
// rtl/ds_scan_latch.sv - latches the 3.5-digit result at EOC and scans it MSD-first onto Q with DS strobes
module ds_scan_latch #(
  parameter int DIG_W = 18,
  parameter int GAP   = 2
) (
  input  logic          CP,
  input  logic          RST,
  ds_scan_latch_if.slave bus
);

  localparam int SLOT_N = GAP + DIG_W;
  localparam int SLOT_W = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_N - 1);
  localparam logic [SLOT_W-1:0] SLOT_GAP  = SLOT_W'(GAP);

  logic       half_q, half_d;
  logic [3:0] d3_q, d3_d;
  logic [3:0] d2_q, d2_d;
  logic [3:0] d1_q, d1_d;
  logic       pol_q, pol_d;
  logic       ovr_q, ovr_d;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        digit_q, digit_d;

  logic [3:0] q_q, q_d;
  logic [3:0] ds_q, ds_d;
  logic       or_n_q, or_n_d;
  logic       dsync_q, dsync_d;

  logic nib_ok;
  logic ur;
  logic active;

  always_comb begin
    half_d = half_q;
    d3_d   = d3_q;
    d2_d   = d2_q;
    d1_d   = d1_q;
    pol_d  = pol_q;
    ovr_d  = ovr_q;
    if (bus.EOC && bus.DU) begin
      half_d = bus.HALF;
      d3_d   = bus.D3;
      d2_d   = bus.D2;
      d1_d   = bus.D1;
      pol_d  = bus.POL;
      ovr_d  = bus.OVR;
    end
  end

  // value < 180 with HALF=0 reduces to D3==0, or D3==1 with D2<=7 (D1 is at most 9 here)
  always_comb begin
    nib_ok = (d3_q <= 4'd9) && (d2_q <= 4'd9) && (d1_q <= 4'd9);
    ur     = nib_ok && !half_q &&
             ((d3_q == 4'd0) || ((d3_q == 4'd1) && (d2_q <= 4'd7)));
  end

  always_comb begin
    slot_d  = slot_q + SLOT_W'(1);
    digit_d = digit_q;
    if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // outputs are derived from the pre-edge slot/digit and latch so a capture shows one edge later
  always_comb begin
    active  = (slot_q >= SLOT_GAP);
    ds_d    = 4'b0000;
    q_d     = 4'b0000;
    dsync_d = 1'b0;
    or_n_d  = ~ovr_q;
    if (active) begin
      ds_d    = 4'b1000 >> digit_q;
      dsync_d = (digit_q == 2'd0) && (slot_q == SLOT_GAP);
      case (digit_q)
        2'd0:    q_d = {half_q, pol_q, 1'b0, ovr_q | ur};
        2'd1:    q_d = d3_q;
        2'd2:    q_d = d2_q;
        default: q_d = d1_q;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      half_q  <= 1'b0;
      d3_q    <= 4'd0;
      d2_q    <= 4'd0;
      d1_q    <= 4'd0;
      pol_q   <= 1'b0;
      ovr_q   <= 1'b0;
      slot_q  <= '0;
      digit_q <= 2'd0;
      q_q     <= 4'b0000;
      ds_q    <= 4'b0000;
      or_n_q  <= 1'b1;
      dsync_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      d3_q    <= d3_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      pol_q   <= pol_d;
      ovr_q   <= ovr_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      q_q     <= q_d;
      ds_q    <= ds_d;
      or_n_q  <= or_n_d;
      dsync_q <= dsync_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.DS    = ds_q;
  assign bus.OR_N  = or_n_q;
  assign bus.DSYNC = dsync_q;

endmodule

// File: tb/tb_ds_scan_latch.sv
// tb/tb_ds_scan_latch.sv - self-checking bench for ds_scan_latch: vector table, corner sequences, random vs model
module tb_ds_scan_latch;
  localparam int DIG_W = 18;
  localparam int GAP   = 2;
  localparam int P     = GAP + DIG_W;

  logic CP;
  logic RST;
  ds_scan_latch_if bus();

  ds_scan_latch #(.DIG_W(DIG_W), .GAP(GAP)) dut (
    .CP (CP),
    .RST(RST),
    .bus(bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int n_vec;
  int n_bad;

  int m_half, m_d3, m_d2, m_d1, m_pol, m_ovr;
  int mt;

  typedef struct {
    logic       du;
    logic       half;
    logic [3:0] d3, d2, d1;
    logic       pol, ovr;
    logic [3:0] q0, q1, q2, q3;
    logic       orn;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got Q=%b DS=%b OR_N=%b DSYNC=%b, expected Q=%b DS=%b OR_N=%b DSYNC=%b",
               nm, $time, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [9:0] model_out();
    int pos, dig, sl, val;
    bit ok, ur;
    logic [3:0] q, ds;
    logic sy;
    pos = mt % (4 * P);
    dig = pos / P;
    sl  = pos % P;
    ok  = (m_d3 < 10) && (m_d2 < 10) && (m_d1 < 10);
    val = m_half * 1000 + m_d3 * 100 + m_d2 * 10 + m_d1;
    ur  = ok && (val < 180);
    q = 4'b0000; ds = 4'b0000; sy = 1'b0;
    if (sl >= GAP) begin
      ds = 4'(8 >> dig);
      sy = (dig == 0) && (sl == GAP);
      case (dig)
        0:       q = {m_half[0], m_pol[0], 1'b0, m_ovr[0] | ur};
        1:       q = m_d3[3:0];
        2:       q = m_d2[3:0];
        default: q = m_d1[3:0];
      endcase
    end
    return {q, ds, ~m_ovr[0], sy};
  endfunction

  task automatic step(input logic rst, input logic eoc, input logic du, input logic half,
                      input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                      input logic pol, input logic ovr);
    logic [9:0] exp;
    RST = rst; bus.EOC = eoc; bus.DU = du; bus.HALF = half;
    bus.D3 = d3; bus.D2 = d2; bus.D1 = d1; bus.POL = pol; bus.OVR = ovr;
    @(posedge CP);
    if (rst) begin
      exp = {4'b0000, 4'b0000, 1'b1, 1'b0};
      m_half = 0; m_d3 = 0; m_d2 = 0; m_d1 = 0; m_pol = 0; m_ovr = 0;
      mt = 0;
    end else begin
      exp = model_out();
      if (eoc && du) begin
        m_half = int'(half); m_d3 = int'(d3); m_d2 = int'(d2); m_d1 = int'(d1);
        m_pol = int'(pol); m_ovr = int'(ovr);
      end
      mt++;
    end
    @(negedge CP);
    check("model", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, exp);
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
         4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_strobe(input logic [3:0] mask, output bit found);
    logic [3:0] prev;
    found = 1'b0;
    prev  = bus.DS;
    for (int k = 0; k < 200 && !found; k++) begin
      step_idle();
      if (bus.DS == mask && prev == 4'b0000) found = 1'b1;
      prev = bus.DS;
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL strobe_timeout: DS=%b never started, expected strobe %b", bus.DS, mask);
    end
  endtask

  initial begin
    bit found;
    logic [3:0] eq;
    n_vec = 0; n_bad = 0; mt = 0;
    m_half = 0; m_d3 = 0; m_d2 = 0; m_d1 = 0; m_pol = 0; m_ovr = 0;

    //            du    half  d3     d2     d1     pol   ovr   q0       q1       q2       q3       orn
    tbl[0] = '{1'b1, 1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 4'b1100, 4'b0010, 4'b0011, 4'b0100, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 4'd9, 4'd3, 4'd4, 1'b1, 1'b0, 4'b1100, 4'b0010, 4'b0011, 4'b0100, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 4'd1, 4'd7, 4'd9, 1'b1, 1'b0, 4'b0101, 4'b0001, 4'b0111, 4'b1001, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 4'd1, 4'd8, 4'd0, 1'b1, 1'b0, 4'b0100, 4'b0001, 4'b1000, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 4'd0, 4'hA, 4'd0, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b1010, 4'b0000, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 1'b1};

    // reset and idle scan timing
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 1'b1);
    for (int c = 0; c <= 82; c++) begin
      step_idle();
      case (c)
        0, 1, 20, 21: check("idle_blank", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0000_0000_1_0);
        2, 82:        check("idle_ds1_rise", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0001_1000_1_1);
        3, 19:        check("idle_ds1_hold", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0001_1000_1_0);
        22:           check("idle_ds2_rise", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0000_0100_1_0);
        default: ;
      endcase
    end

    // capture table: each record is shown on the next full strobe of every digit
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, tbl[i].du, tbl[i].half, tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].pol, tbl[i].ovr);
      for (int d = 0; d < 4; d++) begin
        wait_strobe(4'(8 >> d), found);
        if (found) begin
          case (d)
            0:       eq = tbl[i].q0;
            1:       eq = tbl[i].q1;
            2:       eq = tbl[i].q2;
            default: eq = tbl[i].q3;
          endcase
          check($sformatf("tbl%0d_dig%0d", i, d), {bus.Q, bus.DS, bus.OR_N, 1'b0},
                {eq, 4'(8 >> d), tbl[i].orn, 1'b0});
        end
      end
    end

    // OR_N follows the captured OVR one edge after capture
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1);
    check("orn_capture_edge", {6'd0, bus.OR_N, 3'd0}, {6'd0, 1'b1, 3'd0});
    step_idle();
    check("orn_set", {6'd0, bus.OR_N, 3'd0}, {6'd0, 1'b0, 3'd0});
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0);
    step_idle();
    check("orn_clear", {6'd0, bus.OR_N, 3'd0}, {6'd0, 1'b1, 3'd0});

    // back-to-back captures: the second one wins
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 4'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 4'd5, 4'd4, 1'b0, 1'b0);
    wait_strobe(4'b0100, found);
    if (found) check("b2b_last_wins", {bus.Q, bus.DS, 2'b00}, {4'd6, 4'b0100, 2'b00});

    // reset in the middle of DS3 together with a capture
    wait_strobe(4'b0010, found);
    step_idle();
    step_idle();
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 1'b1);
    check("midrst_clear", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0000_0000_1_0);
    for (int c = 0; c < 3; c++) begin
      step_idle();
      if (c < 2) check("midrst_blank", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0000_0000_1_0);
      else       check("midrst_ds1", {bus.Q, bus.DS, bus.OR_N, bus.DSYNC}, 10'b0001_1000_1_1);
    end

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
           4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
